// File: rtl/playbus_sequencer.sv
// playbus_sequencer: queued FUNC/ADD command initiator for the PlayBus controller.
// Optional build macro PLAYBUS_SEQ_LOOP_EN replays the queue continuously instead of discarding entries.
module playbus_sequencer #(
  parameter int DEPTH      = 4,
  parameter int HOLD_TICKS = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic                   CK2HZ,
  input  logic                   CLR,
  input  logic [2:0]             CMD_FUNC,
  input  logic [3:0]             CMD_ADD,
  input  logic                   CMD_WR,
  input  logic                   RUN,
  input  logic                   ERR_CLR,
  input  logic [1:0]             St,
  output logic [2:0]             FUNC,
  output logic [3:0]             ADD,
  output logic                   GO,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic                   OVF,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic [$clog2(DEPTH):0] COUNT
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (HOLD_TICKS > TIMEOUT) ? HOLD_TICKS : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HOLD, S_GO_WAIT, S_REL_WAIT, S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    func_q, func_d;
  logic [3:0]    add_q, add_d;
  logic          go_q, go_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, push_ok, fin, tout;

  logic [2:0]    fmem_q [DEPTH];
  logic [3:0]    amem_q [DEPTH];

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == TW'(TMAX)) ? v : v + TW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    add_d   = add_q;
    go_d    = go_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tmr_d   = '0;
    fin     = 1'b0;
    tout    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RUN && (count_q != '0) && !err_q) begin
          func_d  = fmem_q[rd_q];
          add_d   = amem_q[rd_q];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (func_q <= 3'd2) begin
          state_d = S_HOLD;
        end else begin
          go_d    = 1'b1;
          state_d = S_GO_WAIT;
        end
      end
      S_HOLD: begin
        if (tmr_q == TW'(HOLD_TICKS - 1)) state_d = S_FINISH;
        else                              tmr_d   = sat_inc(tmr_q);
      end
      S_GO_WAIT: begin
        if (St != 2'd0) begin
          go_d    = 1'b0;
          state_d = S_REL_WAIT;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          go_d    = 1'b0;
          busy_d  = 1'b0;
          tout    = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      S_REL_WAIT: begin
        if (St == 2'd0) begin
          state_d = S_FINISH;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          busy_d  = 1'b0;
          tout    = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        fin     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a timeout in the same cycle as ERR_CLR keeps the flag set
    err_d = tout | (err_q & ~ERR_CLR);
  end

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    wr_d    = wr_q;
    rd_d    = rd_q;
`ifdef PLAYBUS_SEQ_LOOP_EN
    push_ok = CMD_WR & ~full & ~busy_q;
    ovf_d   = CMD_WR & full & ~busy_q;
    // after the newest entry the read pointer jumps back to the oldest one
    if (fin) begin
      if (rd_q + AW'(1) == wr_q) rd_d = wr_q - count_q[AW-1:0];
      else                       rd_d = rd_q + AW'(1);
    end
    count_d = count_q + CW'(push_ok);
`else
    push_ok = CMD_WR & ~full;
    ovf_d   = CMD_WR & full;
    if (fin | tout) rd_d = rd_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(fin | tout);
`endif
    if (push_ok) wr_d = wr_q + AW'(1);
  end

  always_ff @(posedge CK2HZ) begin
    if (CLR) begin
      state_q <= S_IDLE;
      func_q  <= '0;
      add_q   <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tmr_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      add_q   <= add_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      tmr_q   <= tmr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CK2HZ) begin
    if (push_ok) begin
      fmem_q[wr_q] <= CMD_FUNC;
      amem_q[wr_q] <= CMD_ADD;
    end
  end

  assign FUNC  = func_q;
  assign ADD   = add_q;
  assign GO    = go_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign OVF   = ovf_q;
  assign EMPTY = (count_q == '0);
  assign FULL  = full;
  assign COUNT = count_q;

endmodule

// File: tb/tb_playbus_sequencer.sv
// Scoreboard bench for playbus_sequencer with a behavioural PlayBus controller model.
module tb_playbus_sequencer;
  localparam int DEPTH = 4;

  logic       CK2HZ = 1'b0;
  logic       CLR, CMD_WR, RUN, ERR_CLR;
  logic [2:0] CMD_FUNC;
  logic [3:0] CMD_ADD;
  logic [1:0] St = 2'd0;
  logic [2:0] FUNC;
  logic [3:0] ADD;
  logic       GO, BUSY, DONE, ERR, OVF, EMPTY, FULL;
  logic [$clog2(DEPTH):0] COUNT;

  playbus_sequencer #(.DEPTH(DEPTH), .HOLD_TICKS(2), .TIMEOUT(8)) dut (
    .CK2HZ(CK2HZ), .CLR(CLR), .CMD_FUNC(CMD_FUNC), .CMD_ADD(CMD_ADD), .CMD_WR(CMD_WR),
    .RUN(RUN), .ERR_CLR(ERR_CLR), .St(St), .FUNC(FUNC), .ADD(ADD), .GO(GO), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR), .OVF(OVF), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT)
  );

  always #5 CK2HZ = ~CK2HZ;

  typedef struct {
    bit         is_err;
    logic [2:0] f;
    logic [3:0] a;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  bit   err_prev = 1'b0;
  bit   ctl_dead = 1'b0;
  int   ctl_dly = 0;
  int   dly_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CK2HZ);
    #1;
  endtask

  task automatic push(input logic [2:0] f, input logic [3:0] a);
    CMD_FUNC = f;
    CMD_ADD  = a;
    CMD_WR   = 1'b1;
    step();
    CMD_WR   = 1'b0;
  endtask

  // the controller only answers functions 3 and 5; everything else must time out
  task automatic expect_cmd(input logic [2:0] f, input logic [3:0] a);
    exp_t e;
    e.is_err = (f == 3'd4) || (f == 3'd6) || (f == 3'd7);
    e.f = f;
    e.a = a;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || BUSY || COUNT != 0) && n < budget) begin
      if (ERR) ERR_CLR = 1'b1;
      step();
      ERR_CLR = 1'b0;
      n++;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_busy", int'(BUSY), 0);
  endtask

  // PlayBus controller: idle -> start -> write -> end, held until GO drops
  always @(posedge CK2HZ) begin
    if (CLR) begin
      St <= 2'd0;
      dly_cnt <= 0;
    end else begin
      case (St)
        2'd0: begin
          if (GO && !ctl_dead && (FUNC == 3'd3 || FUNC == 3'd5)) begin
            if (dly_cnt >= ctl_dly) begin
              St <= 2'd1;
              dly_cnt <= 0;
            end else begin
              dly_cnt <= dly_cnt + 1;
            end
          end else begin
            dly_cnt <= 0;
          end
        end
        2'd1: St <= 2'd2;
        2'd2: St <= 2'd3;
        default: if (!GO) St <= 2'd0;
      endcase
    end
  end

  always @(negedge CK2HZ) begin
    exp_t e;
    if (!CLR) begin
      if (DONE) begin
        done_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_done", int'({FUNC, ADD}), -1);
        end else begin
          e = sb.pop_front();
          chk("done_event", int'({DONE, FUNC, ADD}), int'({~e.is_err, e.f, e.a}));
        end
`ifdef PLAYBUS_SEQ_LOOP_EN
        chk("loop_count", int'(COUNT), 2);
`endif
      end
      if (ERR && !err_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_err", int'({FUNC, ADD}), -1);
        end else begin
          e = sb.pop_front();
          chk("err_event", int'({ERR, FUNC, ADD}), int'({e.is_err, e.f, e.a}));
        end
      end
      if (GO) chk("go_dynamic_only", int'(FUNC >= 3'd3), 1);
    end
    err_prev = ERR;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, mc, gocnt;
    logic [2:0] f;
    logic [3:0] a;
    logic [2:0] of [5];
    logic [3:0] oa [5];

    CLR = 1'b1; CMD_WR = 1'b0; RUN = 1'b0; ERR_CLR = 1'b0; CMD_FUNC = '0; CMD_ADD = '0;
    step();
    step();
    CLR = 1'b0;
    chk("rst_func", int'(FUNC), 0);
    chk("rst_add", int'(ADD), 0);
    chk("rst_ctl", int'({GO, BUSY, DONE, ERR, OVF}), 0);
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_full", int'(FULL), 0);
    chk("rst_count", int'(COUNT), 0);

`ifdef PLAYBUS_SEQ_LOOP_EN
    push(3'd0, 4'd1);
    push(3'd2, 4'd0);
    expect_cmd(3'd0, 4'd1);
    expect_cmd(3'd2, 4'd0);
    expect_cmd(3'd0, 4'd1);
    RUN = 1'b1;
    n = 0;
    while (!(done_seen >= 2 && BUSY) && n < 200) begin step(); n++; end
    RUN = 1'b0;
    n = 0;
    while ((sb.size() != 0 || BUSY) && n < 100) begin step(); n++; end
    repeat (10) step();
    chk("loop_sb", sb.size(), 0);
    chk("loop_stopped", int'(BUSY), 0);
    chk("loop_count_end", int'(COUNT), 2);
`else
    // static command presented for the hold window
    push(3'd0, 4'd3);
    expect_cmd(3'd0, 4'd3);
    chk("st_count1", int'(COUNT), 1);
    RUN = 1'b1;
    step();
    chk("st_load", int'({BUSY, FUNC, ADD}), int'({1'b1, 3'd0, 4'd3}));
    step();
    chk("st_setup_go", int'(GO), 0);
    step();
    chk("st_hold", int'({GO, FUNC, ADD}), int'({1'b0, 3'd0, 4'd3}));
    step();
    chk("st_nodone_yet", int'(DONE), 0);
    step();
    chk("st_done", int'({DONE, BUSY, EMPTY}), int'({1'b1, 1'b0, 1'b1}));
    chk("st_count0", int'(COUNT), 0);
    step();
    chk("st_done_pulse", int'(DONE), 0);
    RUN = 1'b0;

    // dynamic command with full handshake
    ctl_dly = 0;
    push(3'd5, 4'd0);
    expect_cmd(3'd5, 4'd0);
    RUN = 1'b1;
    step();
    chk("dyn_load", int'({GO, FUNC}), int'({1'b0, 3'd5}));
    step();
    chk("dyn_go_rise", int'(GO), 1);
    step();
    chk("dyn_go_wait", int'({GO, St}), int'({1'b1, 2'd1}));
    step();
    chk("dyn_go_fall", int'({GO, St}), int'({1'b0, 2'd2}));
    n = 0;
    while (!DONE && n < 20) begin step(); n++; end
    chk("dyn_done_st", int'({DONE, St}), int'({1'b1, 2'd0}));
    RUN = 1'b0;
    drain(20);

    // unsupported function times out
    push(3'd6, 4'd2);
    expect_cmd(3'd6, 4'd2);
    RUN = 1'b1;
    gocnt = 0;
    n = 0;
    while (!ERR && n < 40) begin
      step();
      if (GO) gocnt++;
      n++;
    end
    chk("to_go_cycles", gocnt, 8);
    chk("to_state", int'({ERR, GO, BUSY}), int'({1'b1, 1'b0, 1'b0}));
    chk("to_dropped", int'(COUNT), 0);
    push(3'd0, 4'd1);
    expect_cmd(3'd0, 4'd1);
    repeat (4) step();
    chk("to_blocked_busy", int'(BUSY), 0);
    chk("to_blocked_count", int'(COUNT), 1);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    chk("to_err_clr", int'(ERR), 0);
    drain(40);
    RUN = 1'b0;

    // overflow: fifth push dropped, first four run in order
    ctl_dly = 1;
    of = '{3'd1, 3'd3, 3'd2, 3'd5, 3'd0};
    oa = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    for (int i = 0; i < 5; i++) begin
      push(of[i], oa[i]);
      if (i < 4) expect_cmd(of[i], oa[i]);
      chk("ovf_pulse", int'(OVF), (i == 4) ? 1 : 0);
      chk("ovf_count", int'(COUNT), (i < 4) ? i + 1 : 4);
      chk("ovf_full", int'(FULL), (i >= 3) ? 1 : 0);
    end
    step();
    chk("ovf_one_cycle", int'(OVF), 0);
    RUN = 1'b1;
    drain(200);
    repeat (5) step();
    chk("ovf_empty", int'(EMPTY), 1);
    RUN = 1'b0;

    // reset during GO_WAIT
    ctl_dead = 1'b1;
    push(3'd3, 4'd1);
    push(3'd0, 4'd2);
    RUN = 1'b1;
    n = 0;
    while (!GO && n < 20) begin step(); n++; end
    chk("clr_go_seen", int'(GO), 1);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk("clr_state", int'({GO, BUSY, EMPTY, ERR}), int'({1'b0, 1'b0, 1'b1, 1'b0}));
    chk("clr_count", int'(COUNT), 0);
    repeat (5) step();
    chk("clr_no_start", int'({GO, BUSY}), 0);
    RUN = 1'b0;
    ctl_dead = 1'b0;

    // randomized batches against the queue model
    for (int b = 0; b < 10; b++) begin
      n = $urandom_range(1, 6);
      mc = 0;
      ctl_dly = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        f = 3'($urandom_range(0, 7));
        a = 4'($urandom);
        push(f, a);
        chk("rnd_ovf", int'(OVF), (mc == DEPTH) ? 1 : 0);
        if (mc < DEPTH) begin
          expect_cmd(f, a);
          mc++;
        end
        chk("rnd_count", int'(COUNT), mc);
      end
      RUN = 1'b1;
      drain(600);
      RUN = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
